vga_text_controller: RTL
========================

VGA_TEXT_CONTROLLER -- requirements
Module: vga_text_controller

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
  H_ACTIVE 640, visible pixels/line; H_FP 16, H_SYNC 96, H_BP 48, horizontal porch/sync widths;
  V_ACTIVE 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33, vertical porch/sync widths;
  HSYNC_POL 0, VSYNC_POL 0, sync active level; GLYPH_H 16, glyph rows (8 or 16; glyph width fixed at 8);
  BLINK_LOG2 5, cursor blink half-period = 2^BLINK_LOG2 frames.
REQ-002 Derived constants: COLS=H_ACTIVE/8, ROWS=V_ACTIVE/GLYPH_H, CA_W=clog2(COLS*ROWS), FA_W=8+clog2(GLYPH_H).
REQ-003 Ports (name, direction, width, meaning):
  vga_clk in 1, pixel clock, sole clock;
  rst in 1, reset, synchronous, active-high;
  char_addr out CA_W, text-buffer address (row*COLS+col);
  char_data in 8, character code, synchronous RAM, valid one cycle after char_addr;
  font_addr out FA_W, {char_code, glyph_row};
  font_data in 8, glyph row bits, MSB leftmost, valid one cycle after font_addr;
  fg_color in 3, bg_color in 3, global colours, sampled at frame_start;
  cursor_en in 1, cursor_col in 7, cursor_row in 6, cursor control, sampled at frame_start;
  vga_hsync out 1, vga_vsync out 1, sync outputs;
  rgbOut out 3, pixel colour {R,G,B};
  frame_start out 1, one-cycle pulse at counter origin (0,0), undelayed.

Function
REQ-004 hcnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of horizontal widths) and wrap to 0; vcnt SHALL increment at each hcnt wrap and wrap to 0 after V_TOTAL-1.
REQ-005 Raw hsync SHALL be active for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; raw vsync likewise on vcnt; active level per *_POL.
REQ-006 Display-active SHALL be hcnt<H_ACTIVE and vcnt<V_ACTIVE.
REQ-007 Pipeline, for counter position in cycle N: char_addr registered, valid N+1; char_data used N+2; font_addr registered, valid N+3; font_data used N+4; rgbOut registered, valid N+5.
REQ-008 vga_hsync, vga_vsync and display-active SHALL be delayed exactly 5 cycles so they align with rgbOut.
REQ-009 glyph_x=hcnt[2:0] and glyph_row=vcnt mod GLYPH_H SHALL be carried down the pipeline with the pixel.
REQ-010 char_addr SHALL be formed incrementally (row-base register += COLS at each glyph-row boundary; no multiplier); row base SHALL clear at vcnt wrap.
REQ-011 Outside the active area, char_addr and font_addr SHALL hold their last value.
REQ-012 Pixel bit = font_data[7-glyph_x]; rgbOut = bit ? fg : bg; rgbOut SHALL be 0 whenever delayed display-active is 0.
REQ-013 A frame counter SHALL increment at each frame_start; blink phase = bit BLINK_LOG2 of that counter.
REQ-014 When cursor_en=1, the blink phase is 1 and the cell equals (cursor_col,cursor_row), fg and bg SHALL swap for that cell.
REQ-015 A cursor_col>=COLS or cursor_row>=ROWS SHALL show no cursor; it is not an error.
REQ-016 Changes to colour and cursor inputs mid-frame SHALL take effect only at the next frame_start (no tearing).

Reset
REQ-017 While rst=1 at a vga_clk edge: hcnt, vcnt, row base, frame counter, all pipeline registers, char_addr and font_addr SHALL be 0; rgbOut SHALL be 0; syncs SHALL be inactive; frame_start SHALL be 0.
REQ-018 The first edge after rst deasserts SHALL present counter (0,0) and assert frame_start; the full pipeline SHALL be valid 5 cycles later.
REQ-019 Reset mid-frame SHALL abort the frame immediately, with no residual pixels emitted from the flushed pipeline.

Structure
REQ-020 A shared package SHALL hold the default 640x480@60 timing constants, the pipeline latency constant (5) and the colour type (3-bit).
REQ-021 Timing generation (counters, raw sync, active, frame_start) SHALL be one sub-module, vga_timing_gen, reusable by other display blocks.

Verification
REQ-022 Reset release: rst high 3 cycles then low -> frame_start at cycle 1 after release; rgbOut=0; hsync first active 656+5 cycles after origin; line period 800 cycles, frame 525 lines.
REQ-023 Addressing: at (hcnt=17, vcnt=35) -> char_addr=2*80+2=162 one cycle later; char_data=0x41 -> font_addr={0x41,3} two cycles after that.
REQ-024 Pixel: font_data=0x80, fg=3'b111, bg=3'b000 -> rgbOut=7 on glyph_x=0 and 0 on glyph_x 1..7, aligned to delayed active.
REQ-025 Cursor: cursor_en=1, (col 5, row 2), BLINK_LOG2=1 -> cell 162+3 inverted in frames 2-3 and normal in frames 0-1; cursor_col=80 -> never inverted.
REQ-026 Boundary: last active pixel (639,479) has rgbOut driven; hcnt 640 gives rgbOut=0; vcnt wrap resets row base, so char_addr=0 at the next frame origin.
REQ-027 Mid-frame rst at vcnt=200 -> all outputs reset next edge; no nonzero rgbOut until 5 cycles after restart.

Source files
------------

// File: rtl/vga_text_controller_pkg.sv
// Shared timing defaults, pipeline depth and pixel types for the VGA text path.
// Latency: n/a (declarations only).
// Backpressure: n/a; the display path is free-running at the pixel clock.
package vga_text_controller_pkg;

    // 640x480@60 with a 25.175 MHz pixel clock
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Counter position to rgbOut, in pixel clocks
    localparam int PIPE_LAT = 5;

    typedef logic [2:0] color_t;

    // Per-pixel sideband carried alongside the memory lookups
    typedef struct packed {
        logic       active;
        logic       hs;
        logic       vs;
        logic       hit;
        logic [2:0] glyph_x;
        logic [3:0] glyph_row;
    } meta_t;

    function automatic color_t pixel_color(input logic   bit_on,
                                           input logic   swap,
                                           input color_t fg,
                                           input color_t bg);
        color_t fc;
        color_t bc;
        fc = swap ? bg : fg;
        bc = swap ? fg : bg;
        return bit_on ? fc : bc;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters, raw sync flags, display-active and frame origin pulse.
// Latency: outputs are combinational from the counter registers (position valid this cycle).
// Backpressure: none; counters free-run once reset is released.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
)(
    input  logic          vga_clk,
    input  logic          rst,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          hsync_act,
    output logic          vsync_act,
    output logic          active,
    output logic          frame_start,
    output logic          line_end
);

    // Low for the first post-reset cycle so that edge presents the origin instead of skipping it
    logic started;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            hcnt    <= '0;
            vcnt    <= '0;
            started <= 1'b0;
        end else if (!started) begin
            started <= 1'b1;
        end else if (hcnt == HW'(H_TOTAL - 1)) begin
            hcnt <= '0;
            vcnt <= (vcnt == VW'(V_TOTAL - 1)) ? '0 : vcnt + VW'(1);
        end else begin
            hcnt <= hcnt + HW'(1);
        end
    end

    assign line_end    = started && (hcnt == HW'(H_TOTAL - 1));
    assign frame_start = started && (hcnt == '0) && (vcnt == '0);
    assign active      = started && (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
    assign hsync_act   = (hcnt >= HW'(H_ACTIVE + H_FP)) &&
                         (hcnt <= HW'(H_ACTIVE + H_FP + H_SYNC - 1));
    assign vsync_act   = (vcnt >= VW'(V_ACTIVE + V_FP)) &&
                         (vcnt <= VW'(V_ACTIVE + V_FP + V_SYNC - 1));

endmodule

// File: rtl/vga_text_controller.sv
// Text-mode VGA: character RAM and font ROM lookups to an 8xGLYPH_H cell raster with blinking cursor.
// Latency: 5 pixel clocks from counter position to rgbOut/vga_hsync/vga_vsync.
// Backpressure: none; external RAM/ROM must answer one cycle after each address.
module vga_text_controller
    import vga_text_controller_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int HSYNC_POL  = 0,
    parameter int VSYNC_POL  = 0,
    parameter int GLYPH_H    = 16,
    parameter int BLINK_LOG2 = 5,
    localparam int COLS = H_ACTIVE / 8,
    localparam int ROWS = V_ACTIVE / GLYPH_H,
    localparam int CA_W = $clog2(COLS * ROWS),
    localparam int GR_W = $clog2(GLYPH_H),
    localparam int FA_W = 8 + GR_W
)(
    input  logic            vga_clk,
    input  logic            rst,
    output logic [CA_W-1:0] char_addr,
    input  logic [7:0]      char_data,
    output logic [FA_W-1:0] font_addr,
    input  logic [7:0]      font_data,
    input  logic [2:0]      fg_color,
    input  logic [2:0]      bg_color,
    input  logic            cursor_en,
    input  logic [6:0]      cursor_col,
    input  logic [5:0]      cursor_row,
    output logic            vga_hsync,
    output logic            vga_vsync,
    output logic [2:0]      rgbOut,
    output logic            frame_start
);

    localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW          = $clog2(H_TOTAL);
    localparam int VW          = $clog2(V_TOTAL);
    localparam int META_STAGES = PIPE_LAT - 1;
    localparam int FONT_STAGE  = 1;
    localparam int PIX_STAGE   = META_STAGES - 1;
    localparam logic HS_ON     = 1'(HSYNC_POL);
    localparam logic VS_ON     = 1'(VSYNC_POL);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          hs_act;
    logic          vs_act;
    logic          disp_act;
    logic          line_end;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .vga_clk     (vga_clk),
        .rst         (rst),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .hsync_act   (hs_act),
        .vsync_act   (vs_act),
        .active      (disp_act),
        .frame_start (frame_start),
        .line_end    (line_end)
    );

    // Frame-latched presentation state: nothing changes mid-frame
    color_t              fg_q;
    color_t              bg_q;
    logic                cur_en_q;
    logic [6:0]          cur_col_q;
    logic [5:0]          cur_row_q;
    logic                blink_q;
    logic [BLINK_LOG2:0] frame_cnt;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            fg_q      <= '0;
            bg_q      <= '0;
            cur_en_q  <= 1'b0;
            cur_col_q <= '0;
            cur_row_q <= '0;
            blink_q   <= 1'b0;
            frame_cnt <= '0;
        end else if (frame_start) begin
            fg_q      <= fg_color;
            bg_q      <= bg_color;
            cur_en_q  <= cursor_en;
            cur_col_q <= cursor_col;
            cur_row_q <= cursor_row;
            blink_q   <= frame_cnt[BLINK_LOG2];
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // The origin cell is evaluated in the same cycle the latch loads, so bypass it there
    logic       cur_en_e;
    logic [6:0] cur_col_e;
    logic [5:0] cur_row_e;
    logic       blink_e;
    logic       cursor_hit;

    always_comb begin
        cur_en_e  = cur_en_q;
        cur_col_e = cur_col_q;
        cur_row_e = cur_row_q;
        blink_e   = blink_q;
        if (frame_start) begin
            cur_en_e  = cursor_en;
            cur_col_e = cursor_col;
            cur_row_e = cursor_row;
            blink_e   = frame_cnt[BLINK_LOG2];
        end
    end

    assign cursor_hit = cur_en_e && blink_e &&
                        (32'(cur_col_e) == 32'(hcnt >> 3)) &&
                        (32'(cur_row_e) == 32'(vcnt >> GR_W));

    // Start address of the current text row, stepped by COLS at each glyph-row boundary
    logic [CA_W-1:0] row_base;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            row_base <= '0;
        end else if (line_end) begin
            if (vcnt == VW'(V_TOTAL - 1)) begin
                row_base <= '0;
            end else if ((vcnt[GR_W-1:0] == GR_W'(GLYPH_H - 1)) &&
                         (vcnt < VW'(V_ACTIVE - 1))) begin
                row_base <= row_base + CA_W'(COLS);
            end
        end
    end

    meta_t s0;

    always_comb begin
        s0           = '0;
        s0.active    = disp_act;
        s0.hs        = hs_act;
        s0.vs        = vs_act;
        s0.hit       = cursor_hit;
        s0.glyph_x   = hcnt[2:0];
        s0.glyph_row = 4'(vcnt[GR_W-1:0]);
    end

    meta_t pipe [META_STAGES];
    logic  pix_bit;

    assign pix_bit = font_data[3'd7 - pipe[PIX_STAGE].glyph_x];

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            for (int i = 0; i < META_STAGES; i++) begin
                pipe[i] <= '0;
            end
            char_addr <= '0;
            font_addr <= '0;
            rgbOut    <= '0;
            vga_hsync <= ~HS_ON;
            vga_vsync <= ~VS_ON;
        end else begin
            pipe[0] <= s0;
            for (int i = 1; i < META_STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
            if (disp_act) begin
                char_addr <= row_base + CA_W'(hcnt >> 3);
            end
            if (pipe[FONT_STAGE].active) begin
                font_addr <= {char_data, pipe[FONT_STAGE].glyph_row[GR_W-1:0]};
            end
            rgbOut    <= pipe[PIX_STAGE].active ?
                         pixel_color(pix_bit, pipe[PIX_STAGE].hit, fg_q, bg_q) : '0;
            vga_hsync <= pipe[PIX_STAGE].hs ? HS_ON : ~HS_ON;
            vga_vsync <= pipe[PIX_STAGE].vs ? VS_ON : ~VS_ON;
        end
    end

endmodule
